// File: rtl/oflow_buffer_arbiter_if.sv
// rtl/oflow_buffer_arbiter_if.sv - request/grant/buffer bus of the oflow buffer arbiter
// Purpose: bundles frame control, requester handshakes, buffer strobes and slot status.
// Ports: none (clock and reset stay on the arbiter itself).
//   slave  modport: arbiter side (takes frame control and requests, drives grants/buffer/status).
//   master modport: requester/buffer side (the mirror image).
`ifndef NUM_OF_HISTORY_FRAMES_WIDTH
`define NUM_OF_HISTORY_FRAMES_WIDTH 3
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

interface oflow_buffer_arbiter_if;
  logic                                    start_frame;
  logic [`NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames;
  logic                                    wr_req;
  logic                                    rd_req;
  logic [2:0]                              rd_hist;
  logic [`OFFSET_WIDTH-1:0]                rd_offset;
  logic                                    wr_gnt;
  logic                                    rd_gnt;
  logic                                    mem_en;
  logic                                    mem_we;
  logic [2:0]                              mem_slot;
  logic [`ADDR_WIDTH-1:0]                  mem_addr;
  logic                                    rd_valid;
  logic                                    rd_err;
  logic                                    wr_ovf;
  logic [2:0]                              wr_slot;
  logic [`ADDR_WIDTH-1:0]                  end_pointers [5];

  modport slave (
    input  start_frame, num_of_history_frames, wr_req, rd_req, rd_hist, rd_offset,
    output wr_gnt, rd_gnt, mem_en, mem_we, mem_slot, mem_addr, rd_valid, rd_err,
           wr_ovf, wr_slot, end_pointers
  );

  modport master (
    output start_frame, num_of_history_frames, wr_req, rd_req, rd_hist, rd_offset,
    input  wr_gnt, rd_gnt, mem_en, mem_we, mem_slot, mem_addr, rd_valid, rd_err,
           wr_ovf, wr_slot, end_pointers
  );
endinterface

// File: rtl/oflow_buffer_arbiter.sv
// rtl/oflow_buffer_arbiter.sv - write/read arbiter for a 5-slot frame history line buffer
// Purpose: grants one buffer access per decision between a line writer (current frame
//   slot) and a line reader (history frames), rotates the write slot on every frame
//   and tracks the number of stored lines per slot.
// Ports:
//   clk     - single clock, rising edge
//   reset_N - asynchronous active-low reset
//   bus     - oflow_buffer_arbiter_if.slave (frame control, req/gnt, mem_*, status)
// Option: define OFLOW_ARB_RR_EN for round-robin between simultaneous requests;
//   otherwise writes have fixed priority.
`ifndef NUM_OF_HISTORY_FRAMES_WIDTH
`define NUM_OF_HISTORY_FRAMES_WIDTH 3
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module oflow_buffer_arbiter (
  input  logic                 clk,
  input  logic                 reset_N,
  oflow_buffer_arbiter_if.slave bus
);
  localparam int AW = `ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_wr_slot;
  logic [AW-1:0] r_end_ptr [5];
  logic          r_wr_gnt, r_rd_gnt, r_mem_en, r_mem_we;
  logic          r_rd_valid, r_rd_err, r_wr_ovf;
  logic [2:0]    r_mem_slot;
  logic [AW-1:0] r_mem_addr;

  logic [3:0]    w_sum;
  logic [2:0]    w_rd_slot, w_rot_slot;
  logic [AW-1:0] w_wr_ep, w_rd_ep;
  logic          w_full, w_wr_elig, w_rd_ok, w_busy, w_pick_wr;
  logic          w_rotate, w_grant_wr, w_grant_rd, w_ovf;

`ifdef OFLOW_ARB_RR_EN
  // Remembers which side won the last grant; the other side wins the next tie.
  logic r_last_wr;
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)        r_last_wr <= 1'b0;
    else if (w_grant_wr) r_last_wr <= 1'b1;
    else if (w_grant_rd) r_last_wr <= 1'b0;
  end
  assign w_pick_wr = !r_last_wr;
`else
  assign w_pick_wr = 1'b1;
`endif

  // Target history slot; only meaningful for rd_hist 1..4, other values are rejected below.
  assign w_sum     = {1'b0, r_wr_slot} + 4'd5 - {1'b0, bus.rd_hist};
  assign w_rd_slot = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];

  // The first frame after IDLE always lands in slot 0.
  assign w_rot_slot = (r_state == S_IDLE) ? 3'd0 :
                      (r_wr_slot == 3'd4) ? 3'd0 : r_wr_slot + 3'd1;

  // Slot lookups by compare so an out-of-range slot code can never index the array.
  always_comb begin
    w_wr_ep = '0;
    w_rd_ep = '0;
    for (int s = 0; s < 5; s++) begin
      if (r_wr_slot == 3'(s)) w_wr_ep = r_end_ptr[s];
      if (w_rd_slot == 3'(s)) w_rd_ep = r_end_ptr[s];
    end
  end

  assign w_full    = &w_wr_ep;
  assign w_wr_elig = bus.wr_req && !w_full;
  assign w_rd_ok   = (bus.rd_hist != 3'd0) &&
                     (int'(bus.rd_hist) <= int'(bus.num_of_history_frames)) &&
                     (int'(bus.rd_offset) < int'(w_rd_ep));
  // While a grant is on the bus its requester may still show req, so no decision is made.
  assign w_busy    = r_wr_gnt || r_rd_gnt;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rotate    = 1'b0;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    w_ovf       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_frame) begin
          w_state_nxt = S_ROTATE;
          w_rotate    = 1'b1;
        end
      end
      S_ROTATE: w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.start_frame) begin
          // Frame change wins; pending requests simply wait for RUN again.
          w_state_nxt = S_ROTATE;
          w_rotate    = 1'b1;
        end else begin
          w_ovf = bus.wr_req && w_full;
          if (!w_busy) begin
            if (w_wr_elig && bus.rd_req) begin
              w_grant_wr = w_pick_wr;
              w_grant_rd = !w_pick_wr;
            end else begin
              w_grant_wr = w_wr_elig;
              w_grant_rd = bus.rd_req;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_wr_gnt   <= 1'b0;
      r_rd_gnt   <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_slot <= 3'd0;
      r_mem_addr <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_wr_ovf   <= 1'b0;
      r_wr_slot  <= 3'd0;
      for (int s = 0; s < 5; s++) r_end_ptr[s] <= '0;
    end else begin
      r_wr_gnt   <= w_grant_wr;
      r_rd_gnt   <= w_grant_rd;
      r_mem_en   <= w_grant_wr || (w_grant_rd && w_rd_ok);
      r_mem_we   <= w_grant_wr;
      r_rd_err   <= w_grant_rd && !w_rd_ok;
      r_wr_ovf   <= w_ovf;
      // Buffer has one cycle of read latency after the enabled read strobe.
      r_rd_valid <= r_rd_gnt && r_mem_en;
      if (w_grant_wr) begin
        r_mem_slot <= r_wr_slot;
        r_mem_addr <= w_wr_ep;
        r_end_ptr[r_wr_slot] <= w_wr_ep + 1'b1;
      end else if (w_grant_rd && w_rd_ok) begin
        r_mem_slot <= w_rd_slot;
        r_mem_addr <= AW'(bus.rd_offset);
      end else begin
        r_mem_slot <= 3'd0;
        r_mem_addr <= '0;
      end
      if (w_rotate) begin
        r_wr_slot <= w_rot_slot;
        r_end_ptr[w_rot_slot] <= '0;
      end
    end
  end

  assign bus.wr_gnt   = r_wr_gnt;
  assign bus.rd_gnt   = r_rd_gnt;
  assign bus.mem_en   = r_mem_en;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_slot = r_mem_slot;
  assign bus.mem_addr = r_mem_addr;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_err   = r_rd_err;
  assign bus.wr_ovf   = r_wr_ovf;
  assign bus.wr_slot  = r_wr_slot;
  for (genvar g = 0; g < 5; g++) begin : g_ep
    assign bus.end_pointers[g] = r_end_ptr[g];
  end
endmodule

// File: tb/tb_oflow_buffer_arbiter.sv
// tb/tb_oflow_buffer_arbiter.sv - scoreboard bench for oflow_buffer_arbiter
module tb_oflow_buffer_arbiter;
  logic clk = 1'b0;
  logic reset_N;
  always #5 clk = ~clk;

  oflow_buffer_arbiter_if bus();
  oflow_buffer_arbiter dut (.clk(clk), .reset_N(reset_N), .bus(bus));

  typedef struct {
    byte        kind;
    int         cyc;
    logic [2:0] slot;
    logic [3:0] addr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(byte k, int c, int slot, int addr);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.slot = 3'(slot);
    e.addr = 4'(addr);
    sb.push_back(e);
  endtask

  task automatic observe(byte k);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event at cycle %0d: got %c, required none", cyc, k);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("event_kind_%c", e.kind), int'(k), int'(e.kind));
    chk($sformatf("event_cycle_%c", e.kind), cyc, e.cyc);
    if (k == "W" || k == "R") begin
      chk("mem_en", int'(bus.mem_en), 1);
      chk("mem_we", int'(bus.mem_we), (k == "W") ? 1 : 0);
      chk("mem_slot", int'(bus.mem_slot), int'(e.slot));
      chk("mem_addr", int'(bus.mem_addr), int'(e.addr));
    end else if (k == "E") begin
      chk("err_rd_gnt", int'(bus.rd_gnt), 1);
      chk("err_mem_en", int'(bus.mem_en), 0);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event at cycle %0d: got nothing, required %c at cycle %0d",
               cyc, sb[0].kind, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (bus.wr_gnt) observe("W");
    if (bus.rd_gnt && !bus.rd_err) observe("R");
    if (bus.rd_err) observe("E");
    if (bus.wr_ovf) observe("O");
    if (bus.rd_valid) observe("V");
    if (bus.mem_en && !bus.wr_gnt && !bus.rd_gnt) chk("mem_en_without_grant", 1, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int m_slot  = 0;
  bit m_first = 1'b1;
  int m_ep[5] = '{0, 0, 0, 0, 0};

  task automatic do_start();
    bus.start_frame = 1'b1;
    tick();
    bus.start_frame = 1'b0;
    m_slot = m_first ? 0 : (m_slot + 1) % 5;
    m_first = 1'b0;
    m_ep[m_slot] = 0;
    chk("wr_slot_after_start", int'(bus.wr_slot), m_slot);
    tick();
  endtask

  task automatic hold_wr(int n);
    int w;
    w = cyc;
    for (int i = 0; i < n; i++) push("W", w + 1 + 2 * i, m_slot, m_ep[m_slot] + i);
    bus.wr_req = 1'b1;
    repeat (2 * n - 1) tick();
    bus.wr_req = 1'b0;
    m_ep[m_slot] += n;
    tick();
  endtask

  task automatic do_read(int hist, int off, bit ok, int slot);
    bus.rd_hist   = 3'(hist);
    bus.rd_offset = 4'(off);
    if (ok) begin
      push("R", cyc + 1, slot, off);
      push("V", cyc + 2, 0, 0);
    end else begin
      push("E", cyc + 1, 0, 0);
    end
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int a;
    reset_N = 1'b0;
    bus.start_frame = 1'b0;
    bus.num_of_history_frames = 3'd3;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_hist = 3'd0;
    bus.rd_offset = 4'd0;
    repeat (3) tick();
    chk("reset_wr_slot", int'(bus.wr_slot), 0);
    chk("reset_outputs", int'({bus.wr_gnt, bus.rd_gnt, bus.mem_en, bus.mem_we,
                               bus.rd_valid, bus.rd_err, bus.wr_ovf}), 0);
    for (int i = 0; i < 5; i++) chk($sformatf("reset_ep%0d", i), int'(bus.end_pointers[i]), 0);
    reset_N = 1'b1;
    tick();

    // Requests in IDLE get no grant.
    bus.wr_req = 1'b1;
    repeat (2) tick();
    bus.wr_req = 1'b0;
    tick();

    // First frame: three writes at +1,+3,+5, addresses 0,1,2 in slot 0.
    do_start();
    hold_wr(3);
    chk("ep0_after_3_writes", int'(bus.end_pointers[0]), 3);

    // Rotation 1,2,3,4 then wrap to 0 which clears slot 0.
    do_start();
    do_start();
    do_start();
    do_start();
    hold_wr(9);
    chk("ep4_after_9_writes", int'(bus.end_pointers[4]), 9);
    do_start();
    chk("ep0_cleared_on_wrap", int'(bus.end_pointers[0]), 0);
    do_start();

    // Reads from wr_slot 1 with 3 history frames.
    do_read(2, 4, 1'b1, 4);
    do_read(4, 4, 1'b0, 0);
    do_read(2, 9, 1'b0, 0);
    do_read(2, 8, 1'b1, 4);
    do_read(0, 0, 1'b0, 0);
    do_read(3, 0, 1'b0, 0);

    // Simultaneous requests held for four grants.
    bus.rd_hist = 3'd2;
    bus.rd_offset = 4'd0;
    a = cyc;
`ifdef OFLOW_ARB_RR_EN
    push("W", a + 1, 1, 0);
    push("R", a + 3, 4, 0);
    push("V", a + 4, 0, 0);
    push("W", a + 5, 1, 1);
    push("R", a + 7, 4, 0);
    push("V", a + 8, 0, 0);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    repeat (7) tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    repeat (2) tick();
    chk("ep1_after_arb", int'(bus.end_pointers[1]), 2);
`else
    for (int i = 0; i < 4; i++) push("W", a + 1 + 2 * i, 1, i);
    push("R", a + 9, 4, 0);
    push("V", a + 10, 0, 0);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    repeat (7) tick();
    bus.wr_req = 1'b0;
    repeat (2) tick();
    bus.rd_req = 1'b0;
    repeat (2) tick();
    chk("ep1_after_arb", int'(bus.end_pointers[1]), 4);
`endif

    // Fill slot 2 to all-ones, then overflow for three requested cycles.
    do_start();
    hold_wr(15);
    chk("ep2_full", int'(bus.end_pointers[2]), 15);
    a = cyc;
    push("O", a + 1, 0, 0);
    push("O", a + 2, 0, 0);
    push("O", a + 3, 0, 0);
    bus.wr_req = 1'b1;
    repeat (3) tick();
    bus.wr_req = 1'b0;
    repeat (2) tick();

    // start_frame together with wr_req: grant only after ROTATE, into slot 3.
    a = cyc;
    push("W", a + 3, 3, 0);
    bus.start_frame = 1'b1;
    bus.wr_req = 1'b1;
    tick();
    bus.start_frame = 1'b0;
    chk("wr_slot_rotated_3", int'(bus.wr_slot), 3);
    repeat (2) tick();
    bus.wr_req = 1'b0;
    tick();

    // Write granted just before start_frame completes into the old slot.
    a = cyc;
    push("W", a + 1, 3, 1);
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    bus.start_frame = 1'b1;
    tick();
    bus.start_frame = 1'b0;
    chk("ep3_old_slot_write", int'(bus.end_pointers[3]), 2);
    chk("wr_slot_rotated_4", int'(bus.wr_slot), 4);
    tick();

    // Read granted just before start_frame still delivers rd_valid.
    a = cyc;
    bus.rd_hist = 3'd1;
    bus.rd_offset = 4'd1;
    push("R", a + 1, 3, 1);
    push("V", a + 2, 0, 0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    bus.start_frame = 1'b1;
    tick();
    bus.start_frame = 1'b0;
    chk("wr_slot_rotated_0", int'(bus.wr_slot), 0);
    repeat (2) tick();

    // Reset during a read grant: outputs clear at once, no rd_valid afterwards.
    a = cyc;
    bus.rd_hist = 3'd2;
    bus.rd_offset = 4'd0;
    push("R", a + 1, 3, 0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    #1;
    reset_N = 1'b0;
    #1;
    chk("async_reset_rd_gnt", int'(bus.rd_gnt), 0);
    chk("async_reset_mem_en", int'(bus.mem_en), 0);
    chk("async_reset_ep3", int'(bus.end_pointers[3]), 0);
    repeat (2) tick();
    reset_N = 1'b1;
    repeat (4) tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
